// File: rtl/neck_pkg.sv
// Shared definitions for the neck detector: FSM state encoding,
// default sample width and the event counter width.
package neck_pkg;

  localparam int DW_DEF = 13;
  localparam int EVT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_ALARM   = 2'd3
  } neck_state_e;

endpackage : neck_pkg

// File: rtl/neck_if.sv
// Derivative sample stream from the differentiator into the neck detector.
interface neck_if #(
  parameter int DW = 13
);
  logic                 sample_vld;
  logic signed [DW-1:0] first_dif;
  logic signed [DW-1:0] third_dif;

  modport master (output sample_vld, output first_dif, output third_dif);
  modport slave  (input  sample_vld, input  first_dif, input  third_dif);
endinterface : neck_if

// File: rtl/neck_qualify.sv
// Combinational sample qualification: steep negative slope with a large jerk.
// All arithmetic is done two bits wider so negating the most negative sample cannot wrap.
module neck_qualify #(
  parameter int DW = 13
) (
  input  logic                 sample_vld,
  input  logic signed [DW-1:0] first_dif,
  input  logic signed [DW-1:0] third_dif,
  input  logic        [DW-1:0] th_slope,
  input  logic        [DW-1:0] th_jerk,
  output logic                 qualify,
  output logic        [DW:0]   abs_jerk
);

  logic signed [DW+1:0] fd_w_s;
  logic signed [DW+1:0] td_w_s;
  logic signed [DW+1:0] neg_slope_s;
  logic signed [DW+1:0] jerk_th_s;
  logic signed [DW+1:0] abs_w_s;

  // Widen, take magnitudes and compare against the thresholds.
  always_comb begin
    fd_w_s      = {{2{first_dif[DW-1]}}, first_dif};
    td_w_s      = {{2{third_dif[DW-1]}}, third_dif};
    neg_slope_s = -$signed({2'b00, th_slope});
    jerk_th_s   = $signed({2'b00, th_jerk});
    if (td_w_s[DW+1]) begin
      abs_w_s = -td_w_s;
    end else begin
      abs_w_s = td_w_s;
    end
    qualify  = sample_vld && (fd_w_s <= neg_slope_s) && (abs_w_s >= jerk_th_s);
    abs_jerk = abs_w_s[DW:0];
  end

endmodule : neck_qualify

// File: rtl/neck_detect.sv
// Neck detector: confirms a run of qualifying derivative samples, raises a
// pulse and latched alarm, then ignores a fixed number of samples.
module neck_detect
  import neck_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int CONFIRM_N = 4,
  parameter int HOLDOFF_N = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  neck_if.slave            smp,
  input  logic [DW-1:0]    th_slope,
  input  logic [DW-1:0]    th_jerk,
  input  logic             clr,
  output logic             neck_pulse,
  output logic             neck_alarm,
  output logic [EVT_W-1:0] event_cnt,
  output logic [DW:0]      peak_jerk,
  output logic [1:0]       state
);

  neck_state_e      state_r, state_nxt_s;
  logic [7:0]       hit_r, hit_nxt_s;
  logic [7:0]       hold_r, hold_nxt_s;
  logic [DW:0]      peak_r, peak_nxt_s;
  logic             pulse_r, pulse_nxt_s;
  logic             alarm_r, alarm_nxt_s;
  logic [EVT_W-1:0] evt_r, evt_nxt_s, evt_base_s;
  logic [DW:0]      pj_r, pj_nxt_s;
  logic             qual_s;
  logic [DW:0]      abs_s;
  logic [DW:0]      peak_max_s;
  logic [DW:0]      entry_peak_s;
  logic             enter_s;
  logic [8:0]       hit_inc_s;
  logic [8:0]       hold_inc_s;

  neck_qualify #(.DW(DW)) u_qualify (
    .sample_vld (smp.sample_vld),
    .first_dif  (smp.first_dif),
    .third_dif  (smp.third_dif),
    .th_slope   (th_slope),
    .th_jerk    (th_jerk),
    .qualify    (qual_s),
    .abs_jerk   (abs_s)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt_s  = state_r;
    hit_nxt_s    = hit_r;
    hold_nxt_s   = hold_r;
    peak_nxt_s   = peak_r;
    pulse_nxt_s  = 1'b0;
    alarm_nxt_s  = clr ? 1'b0 : alarm_r;
    evt_base_s   = clr ? {EVT_W{1'b0}} : evt_r;
    evt_nxt_s    = evt_base_s;
    pj_nxt_s     = clr ? {(DW+1){1'b0}} : pj_r;
    enter_s      = 1'b0;
    entry_peak_s = peak_r;
    peak_max_s   = (abs_s > peak_r) ? abs_s : peak_r;
    hit_inc_s    = {1'b0, hit_r} + 9'd1;
    hold_inc_s   = {1'b0, hold_r} + 9'd1;

    if (!en) begin
      state_nxt_s = ST_IDLE;
      hit_nxt_s   = 8'd0;
      hold_nxt_s  = 8'd0;
      peak_nxt_s  = {(DW+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_ARMED;
        end
        ST_ARMED: begin
          if (qual_s) begin
            hit_nxt_s    = 8'd1;
            peak_nxt_s   = abs_s;
            entry_peak_s = abs_s;
            state_nxt_s  = ST_CONFIRM;
            enter_s      = (9'd1 >= 9'(CONFIRM_N));
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_CONFIRM: begin
          if (qual_s) begin
            hit_nxt_s    = hit_inc_s[7:0];
            peak_nxt_s   = peak_max_s;
            entry_peak_s = peak_max_s;
            enter_s      = (hit_inc_s >= 9'(CONFIRM_N));
          end else if (smp.sample_vld) begin
            state_nxt_s = ST_ARMED;
            hit_nxt_s   = 8'd0;
            peak_nxt_s  = {(DW+1){1'b0}};
          end else begin
            state_nxt_s = ST_CONFIRM;
          end
        end
        ST_ALARM: begin
          // Samples arriving in holdoff only advance the holdoff count.
          if (smp.sample_vld) begin
            if (hold_inc_s >= 9'(HOLDOFF_N)) begin
              state_nxt_s = ST_ARMED;
              hold_nxt_s  = 8'd0;
            end else begin
              hold_nxt_s = hold_inc_s[7:0];
            end
          end else begin
            hold_nxt_s = hold_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    // Confirmation wins over a coincident clr.
    if (enter_s) begin
      state_nxt_s = ST_ALARM;
      pulse_nxt_s = 1'b1;
      alarm_nxt_s = 1'b1;
      evt_nxt_s   = (evt_base_s == {EVT_W{1'b1}}) ? evt_base_s : evt_base_s + {{(EVT_W-1){1'b0}}, 1'b1};
      pj_nxt_s    = entry_peak_s;
      hit_nxt_s   = 8'd0;
      hold_nxt_s  = 8'd0;
      peak_nxt_s  = {(DW+1){1'b0}};
    end else begin
      pulse_nxt_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      hit_r   <= 8'd0;
      hold_r  <= 8'd0;
      peak_r  <= {(DW+1){1'b0}};
      pulse_r <= 1'b0;
      alarm_r <= 1'b0;
      evt_r   <= {EVT_W{1'b0}};
      pj_r    <= {(DW+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      hit_r   <= hit_nxt_s;
      hold_r  <= hold_nxt_s;
      peak_r  <= peak_nxt_s;
      pulse_r <= pulse_nxt_s;
      alarm_r <= alarm_nxt_s;
      evt_r   <= evt_nxt_s;
      pj_r    <= pj_nxt_s;
    end
  end

  assign neck_pulse = pulse_r;
  assign neck_alarm = alarm_r;
  assign event_cnt  = evt_r;
  assign peak_jerk  = pj_r;
  assign state      = state_r;

endmodule : neck_detect
